// File: rtl/gloves_pos_ctl.sv
// Gloves position controller: samples the mouse once per frame at the rise of
// vertical blanking, clamps the target to the visible area and moves the
// registered gloves position toward it by at most MAX_STEP pixels per axis.
module gloves_pos_ctl #(
  parameter int unsigned H_MAX    = 1023,
  parameter int unsigned V_MAX    = 767,
  parameter int unsigned MAX_STEP = 16,
  parameter int unsigned RST_X    = 512,
  parameter int unsigned RST_Y    = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        vblnk,
  input  logic        enable,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pos_valid
);

  typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE} state_t;

  localparam logic [11:0]        H_MAX_C = 12'(H_MAX);
  localparam logic [11:0]        V_MAX_C = 12'(V_MAX);
  localparam logic [11:0]        STEP_U  = 12'(MAX_STEP);
  localparam logic signed [12:0] STEP_P  = 13'(MAX_STEP);
  localparam logic signed [12:0] STEP_N  = 13'(-int'(MAX_STEP));

  state_t             state_q, state_d;
  logic               vblnk_q, vblnk_d;
  logic [11:0]        tgt_x_q, tgt_x_d;
  logic [11:0]        tgt_y_q, tgt_y_d;
  logic signed [12:0] dx_q, dx_d;
  logic signed [12:0] dy_q, dy_d;
  logic [11:0]        xpos_q, xpos_d;
  logic [11:0]        ypos_q, ypos_d;
  logic               pos_valid_q, pos_valid_d;
  logic               vb_rise;

  // Move one axis toward its target, limited to MAX_STEP per frame.
  function automatic logic [11:0] step_axis(input logic [11:0]        cur,
                                            input logic [11:0]        tgt,
                                            input logic signed [12:0] d);
    if (d > STEP_P)      return cur + STEP_U;
    else if (d < STEP_N) return cur - STEP_U;
    else                 return tgt;
  endfunction

  assign vb_rise = vblnk & ~vblnk_q;

  // Next-state and datapath: capture targets, form differences, apply step.
  always_comb begin
    state_d     = state_q;
    vblnk_d     = vblnk;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    pos_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (vb_rise && enable) begin
          state_d = CAPTURE;
          tgt_x_d = (mouse_xpos > H_MAX_C) ? H_MAX_C : mouse_xpos;
          tgt_y_d = (mouse_ypos > V_MAX_C) ? V_MAX_C : mouse_ypos;
        end
      end
      CAPTURE: begin
        dx_d    = $signed({1'b0, tgt_x_q} - {1'b0, xpos_q});
        dy_d    = $signed({1'b0, tgt_y_q} - {1'b0, ypos_q});
        state_d = UPDATE;
      end
      UPDATE: begin
        xpos_d      = step_axis(xpos_q, tgt_x_q, dx_q);
        ypos_d      = step_axis(ypos_q, tgt_y_q, dy_q);
        pos_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; vblnk_q resets high so a blanking interval
  // already in progress at reset release is not mistaken for a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vblnk_q     <= 1'b1;
      tgt_x_q     <= 12'(RST_X);
      tgt_y_q     <= 12'(RST_Y);
      dx_q        <= '0;
      dy_q        <= '0;
      xpos_q      <= 12'(RST_X);
      ypos_q      <= 12'(RST_Y);
      pos_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblnk_q     <= vblnk_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      pos_valid_q <= pos_valid_d;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign pos_valid = pos_valid_q;

endmodule

// File: tb/tb_gloves_pos_ctl.sv
// Randomized self-checking bench for gloves_pos_ctl against a per-frame
// arithmetic model of the gloves position.
module tb_gloves_pos_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic        pos_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_x    = 512;
  int exp_y    = 384;

  gloves_pos_ctl #(
    .H_MAX   (1023),
    .V_MAX   (767),
    .MAX_STEP(16),
    .RST_X   (512),
    .RST_Y   (384)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .vblnk     (vblnk),
    .enable    (enable),
    .xpos      (xpos),
    .ypos      (ypos),
    .pos_valid (pos_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic int step_to(input int cur, input int tgt);
    int d = tgt - cur;
    if (d > 16)       return cur + 16;
    else if (d < -16) return cur - 16;
    else              return tgt;
  endfunction

  task automatic check_pos(input string tag, input int pv);
    check({tag, ".x"}, int'(xpos), exp_x);
    check({tag, ".y"}, int'(ypos), exp_y);
    check({tag, ".valid"}, int'(pos_valid), pv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_x = 512;
    exp_y = 384;
    check_pos("rst_async", 0);
    repeat (2) @(negedge clk);
    vblnk = 1'b1;
    rst   = 1'b1;
  endtask

  // One frame: vblnk low, inputs set, vblnk rises; outputs checked on every
  // cycle up to one after the expected update. rst_mid=1 asserts reset while
  // the update is in flight, rst_mid=2 right after it lands.
  task automatic frame(input int mx, input int my, input bit en, input int rst_mid);
    @(negedge clk);
    vblnk      = 1'b0;
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    enable     = en;
    repeat (2) @(negedge clk);
    check_pos("pre", 0);
    vblnk = 1'b1;
    @(negedge clk);
    check_pos("cap", 0);
    mouse_xpos = 12'($urandom);
    mouse_ypos = 12'($urandom);
    enable     = 1'($urandom);
    @(negedge clk);
    check_pos("upd", 0);
    if (rst_mid == 1) begin
      rst = 1'b0;
      #1;
      exp_x = 512;
      exp_y = 384;
      check_pos("rst_in_update", 0);
      @(negedge clk);
      check_pos("rst_update_lost", 0);
      rst = 1'b1;
      return;
    end
    if (en) begin
      exp_x = step_to(exp_x, clampi(mx, 1023));
      exp_y = step_to(exp_y, clampi(my, 767));
    end
    @(negedge clk);
    check_pos("done", int'(en));
    if (rst_mid == 2) begin
      rst = 1'b0;
      #1;
      exp_x = 512;
      exp_y = 384;
      check_pos("rst_after_update", 0);
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    @(negedge clk);
    check_pos("post", 0);
  endtask

  initial begin
    // Reset held with random inputs, then released during blanking.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mouse_xpos = 12'($urandom);
      mouse_ypos = 12'($urandom);
      vblnk      = 1'($urandom);
      enable     = 1'($urandom);
      #1;
      check_pos("rst_hold", 0);
    end
    @(negedge clk);
    vblnk  = 1'b1;
    enable = 1'b1;
    rst    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_pos("rst_release", 0);
    end

    // Small move.
    frame(520, 380, 1'b1, 0);

    // Rate limit from the reset position.
    do_reset();
    for (int i = 0; i < 3; i++) frame(1000, 100, 1'b1, 0);
    check("rate_x", exp_x, 560);
    check("rate_y", exp_y, 336);

    // Clamp: converge to the corner, then one more frame with no movement.
    for (int i = 0; i < 32; i++) frame(1500, 900, 1'b1, 0);
    check("clamp_x", int'(xpos), 1023);
    check("clamp_y", int'(ypos), 767);
    frame(1500, 900, 1'b1, 0);

    // Freeze while disabled.
    for (int i = 0; i < 2; i++) frame(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b0, 0);

    // Random frames, mixing far jumps with small nearby moves.
    for (int i = 0; i < 40; i++) begin
      int mx, my;
      if ($urandom_range(0, 1) == 0) begin
        mx = int'($urandom_range(0, 4095));
        my = int'($urandom_range(0, 4095));
      end else begin
        mx = exp_x + int'($urandom_range(0, 60)) - 30;
        my = exp_y + int'($urandom_range(0, 60)) - 30;
        if (mx < 0) mx = 0;
        if (my < 0) my = 0;
      end
      frame(mx, my, ($urandom_range(0, 3) != 0), 0);
    end

    // Reset during and right after an update.
    frame(100, 700, 1'b1, 0);
    frame(100, 700, 1'b1, 1);
    frame(900, 50, 1'b1, 0);
    frame(900, 50, 1'b1, 2);
    frame(600, 400, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
